bist_seq_ctrl: RTL and testbench

//  Built-in self-test sequencer for the 3-in/6-out s298 sequential core.
//  - Drives the core's primary inputs G0..G2 with LFSR pseudo-random patterns.
//  - Compacts the core's six outputs into a 16-bit MISR signature.
//  - Compares the signature against a golden value and reports PASS.
//  - Sits between the core and the test-access wrapper; runs one self-test per START.

---
 rtl/bist_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bist_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bist_seq_ctrl
// Built-in self-test sequencer for the s298 sequential core (3 inputs,
// 6 outputs). One self-test per accepted START:
//   IDLE -> INIT (core held cleared with G0=1) -> RUN (LFSR patterns applied,
//   core outputs compacted into a MISR) -> CMP (signature vs GOLDEN) -> IDLE.
//
// Ports
//   CK      in   1   clock, rising edge
//   RST     in   1   synchronous reset, active-high, highest priority
//   START   in   1   begin a test (only looked at in IDLE)
//   ABORT   in   1   cancel a running test (INIT/RUN/CMP), DONE stays 0
//   CUT_PO  in   6   core outputs G66,G67,G117,G118,G132,G133
//   CUT_PI  out  3   core inputs G0,G1,G2
//   BUSY    out  1   high in INIT, RUN and CMP
//   DONE    out  1   sticky completion flag, cleared by next accepted START
//   PASS    out  1   signature matched GOLDEN (valid when DONE=1)
//   SIG     out  16  current MISR contents
// -----------------------------------------------------------------------------
module bist_seq_ctrl #(
    parameter int          CYCLES   = 1024,
    parameter int          INIT_CYC = 4,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [15:0] GOLDEN   = 16'h0000
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        START,
    input  logic        ABORT,
    input  logic [5:0]  CUT_PO,
    output logic [2:0]  CUT_PI,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [15:0] SIG
);

    // One counter serves both INIT and RUN, so it is sized for the longer one.
    localparam int               CNT_MAX   = (CYCLES > INIT_CYC) ? CYCLES : INIT_CYC;
    localparam int               CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_CMP  = 2'd3;

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // MISR with the same polynomial, core outputs folded into the low bits
    function automatic logic [15:0] misr_step(input logic [15:0] v, input logic [5:0] po);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]} ^ {10'b0, po};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [15:0]      lfsr_q,  lfsr_d;
    logic [15:0]      misr_q,  misr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             pass_q,  pass_d;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                // START outranks a coincident ABORT here, since ABORT is not
                // looked at in IDLE at all.
                if (START) begin
                    state_d = S_INIT;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    misr_d  = 16'h0000;
                    lfsr_d  = SEED_EFF;
                    cnt_d   = '0;
                end
            end
            S_INIT: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == INIT_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                // An aborting edge leaves the MISR as it was; only completed
                // RUN cycles are compacted.
                if (ABORT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    misr_d = misr_step(misr_q, CUT_PO);
                    lfsr_d = lfsr_step(lfsr_q);
                    if (cnt_q == RUN_LAST) begin
                        state_d = S_CMP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (!ABORT) begin
                    pass_d = (misr_q == GOLDEN);
                    done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            misr_q  <= 16'h0000;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // G0 doubles as the core's clear: held high in INIT, and pulsed in RUN
    // only when the low LFSR nibble is all ones.
    always_comb begin
        CUT_PI = 3'b000;
        case (state_q)
            S_INIT:  CUT_PI = 3'b001;
            S_RUN:   CUT_PI = {lfsr_q[2:1], (lfsr_q[3:0] == 4'hF)};
            default: CUT_PI = 3'b000;
        endcase
    end

    assign BUSY = (state_q != S_IDLE);
    assign DONE = done_q;
    assign PASS = pass_q;
    assign SIG  = misr_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
module tb_bist_seq_ctrl;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0, start_e = 1'b0;
    logic abort_a = 1'b0, abort_n = 1'b0;
    logic [5:0] po_a = 6'h00, po_b = 6'h3F, po_c = 6'h01, po_d = 6'h00;
    logic [5:0] po_e, core_st, fault_mask = 6'h00;
    logic core_clr = 1'b0;

    logic [2:0]  pi_a, pi_b, pi_c, pi_d, pi_e;
    logic        busy_a, busy_b, busy_c, busy_d, busy_e;
    logic        done_a, done_b, done_c, done_d, done_e;
    logic        pass_a, pass_b, pass_c, pass_d, pass_e;
    logic [15:0] sig_a, sig_b, sig_c, sig_d, sig_e;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
    } exp_t;
    exp_t sb_q[$];

    bist_seq_ctrl #(.CYCLES(4), .INIT_CYC(4), .SEED(16'hACE1), .GOLDEN(16'h0000)) u_a (
        .CK(ck), .RST(rst), .START(start_a), .ABORT(abort_a), .CUT_PO(po_a),
        .CUT_PI(pi_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .SIG(sig_a));
    bist_seq_ctrl #(.CYCLES(1), .INIT_CYC(1), .SEED(16'hACE1), .GOLDEN(16'h0000)) u_b (
        .CK(ck), .RST(rst), .START(start_b), .ABORT(abort_n), .CUT_PO(po_b),
        .CUT_PI(pi_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .SIG(sig_b));
    bist_seq_ctrl #(.CYCLES(2), .INIT_CYC(2), .SEED(16'hACE1), .GOLDEN(16'h0000)) u_c (
        .CK(ck), .RST(rst), .START(start_c), .ABORT(abort_n), .CUT_PO(po_c),
        .CUT_PI(pi_c), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .SIG(sig_c));
    bist_seq_ctrl #(.CYCLES(4), .INIT_CYC(4), .SEED(16'h0000), .GOLDEN(16'h0000)) u_d (
        .CK(ck), .RST(rst), .START(start_d), .ABORT(abort_n), .CUT_PO(po_d),
        .CUT_PI(pi_d), .BUSY(busy_d), .DONE(done_d), .PASS(pass_d), .SIG(sig_d));
    bist_seq_ctrl #(.CYCLES(1024), .INIT_CYC(4), .SEED(16'hACE1), .GOLDEN(16'h0000)) u_e (
        .CK(ck), .RST(rst), .START(start_e), .ABORT(abort_n), .CUT_PO(po_e),
        .CUT_PI(pi_e), .BUSY(busy_e), .DONE(done_e), .PASS(pass_e), .SIG(sig_e));

    // Stand-in sequential core driven by the sequencer's CUT_PI
    always @(posedge ck) begin
        if (rst || core_clr) core_st <= 6'h00;
        else                 core_st <= {core_st[4:0], core_st[5] ^ core_st[2]} ^ {pi_e, pi_e};
    end
    assign po_e = core_st ^ fault_mask;

    function automatic logic [15:0] m_lfsr(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] v, input logic [5:0] po);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]} ^ {10'b0, po};
    endfunction

    function automatic logic [2:0] m_pi(input logic [15:0] v);
        return {v[2:1], (v[3:0] == 4'hF)};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge ck);
        @(negedge ck);
        checks++; if ({busy_a, done_a, pass_a, pi_a, sig_a} !== 22'h0) begin failures++; $display("FAIL reset_a got=%h exp=0", {busy_a, done_a, pass_a, pi_a, sig_a}); end
        checks++; if ({busy_b, done_b, pass_b, pi_b, sig_b} !== 22'h0) begin failures++; $display("FAIL reset_b got=%h exp=0", {busy_b, done_b, pass_b, pi_b, sig_b}); end
        checks++; if ({busy_c, done_c, pass_c, pi_c, sig_c} !== 22'h0) begin failures++; $display("FAIL reset_c got=%h exp=0", {busy_c, done_c, pass_c, pi_c, sig_c}); end
        checks++; if ({busy_d, done_d, pass_d, pi_d, sig_d} !== 22'h0) begin failures++; $display("FAIL reset_d got=%h exp=0", {busy_d, done_d, pass_d, pi_d, sig_d}); end
        checks++; if ({busy_e, done_e, pass_e, pi_e, sig_e} !== 22'h0) begin failures++; $display("FAIL reset_e got=%h exp=0", {busy_e, done_e, pass_e, pi_e, sig_e}); end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ck);
            checks++;
            if ({busy_a, done_a, pass_a, pi_a, sig_a} !== 22'h0) begin
                failures++; $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, {busy_a, done_a, pass_a, pi_a, sig_a});
            end
        end
    endtask

    task automatic test_timing;
        logic [15:0] m = 16'hACE1;
        logic [2:0]  exp_pi;
        int          busy_n = 0;
        exp_t        e;
        sb_q.push_back('{sig: 16'h0000, pass: 1'b1});
        @(negedge ck) start_a = 1'b1;
        @(posedge ck); #1 start_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ck);
            if (!busy_a) break;
            busy_n++;
            if (busy_n <= 4) exp_pi = 3'b001;
            else if (busy_n <= 8) begin exp_pi = m_pi(m); m = m_lfsr(m); end
            else exp_pi = 3'b000;
            checks++;
            if (pi_a !== exp_pi) begin failures++; $display("FAIL timing_pi cyc=%0d got=%b exp=%b", busy_n, pi_a, exp_pi); end
            if (busy_n == 6) begin
                checks++;
                if (pi_a !== 3'b010) begin failures++; $display("FAIL lfsr_59c3_pi got=%b exp=010", pi_a); end
            end
        end
        checks++; if (busy_n != 9) begin failures++; $display("FAIL busy_len got=%0d exp=9", busy_n); end
        e = sb_q.pop_front();
        checks++; if ({done_a, pass_a, sig_a} !== {1'b1, e.pass, e.sig}) begin
            failures++; $display("FAIL timing_result got=%b/%b/%h exp=1/%b/%h", done_a, pass_a, sig_a, e.pass, e.sig);
        end
        repeat (3) @(negedge ck);
        checks++; if ({done_a, pass_a} !== 2'b11) begin failures++; $display("FAIL done_sticky got=%b exp=11", {done_a, pass_a}); end
    endtask

    task automatic test_misr;
        exp_t e;
        bit   seen;
        sb_q.push_back('{sig: 16'h003F, pass: 1'b0});
        @(negedge ck) start_b = 1'b1;
        @(posedge ck); #1 start_b = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge ck); seen = done_b; end
        e = sb_q.pop_front();
        checks++; if (!seen || {pass_b, sig_b} !== {e.pass, e.sig}) begin
            failures++; $display("FAIL misr_1cyc done=%b got=%b/%h exp=%b/%h", seen, pass_b, sig_b, e.pass, e.sig);
        end
        sb_q.push_back('{sig: 16'h0003, pass: 1'b0});
        @(negedge ck) start_c = 1'b1;
        @(posedge ck); #1 start_c = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge ck); seen = done_c; end
        e = sb_q.pop_front();
        checks++; if (!seen || {pass_c, sig_c} !== {e.pass, e.sig}) begin
            failures++; $display("FAIL misr_2cyc done=%b got=%b/%h exp=%b/%h", seen, pass_c, sig_c, e.pass, e.sig);
        end
    endtask

    task automatic test_seed_zero;
        exp_t e;
        bit   seen = 0;
        sb_q.push_back('{sig: 16'h0000, pass: 1'b1});
        @(negedge ck) start_d = 1'b1;
        @(posedge ck); #1 start_d = 1'b0;
        repeat (5) @(negedge ck);
        checks++; if (pi_d !== 3'b000) begin failures++; $display("FAIL seed0_run0 got=%b exp=000", pi_d); end
        @(negedge ck);
        checks++; if (pi_d !== 3'b010) begin failures++; $display("FAIL seed0_run1 got=%b exp=010", pi_d); end
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge ck); seen = done_d; end
        e = sb_q.pop_front();
        checks++; if (!seen || {pass_d, sig_d} !== {e.pass, e.sig}) begin
            failures++; $display("FAIL seed0_result done=%b got=%b/%h exp=%b/%h", seen, pass_d, sig_d, e.pass, e.sig);
        end
    endtask

    task automatic test_abort;
        int   busy_n = 0;
        exp_t e;
        // ABORT in IDLE is ignored
        @(negedge ck) abort_a = 1'b1;
        @(posedge ck); #1 abort_a = 1'b0;
        @(negedge ck);
        checks++; if ({busy_a, done_a} !== 2'b01) begin failures++; $display("FAIL abort_idle got=%b exp=01", {busy_a, done_a}); end
        // START and ABORT together in IDLE: START wins
        @(negedge ck) begin start_a = 1'b1; abort_a = 1'b1; end
        @(posedge ck); #1 begin start_a = 1'b0; abort_a = 1'b0; end
        @(negedge ck);
        checks++; if ({busy_a, done_a} !== 2'b10) begin failures++; $display("FAIL start_abort got=%b exp=10", {busy_a, done_a}); end
        // ABORT in RUN cycle 2
        repeat (6) @(negedge ck);
        abort_a = 1'b1;
        @(posedge ck); #1 abort_a = 1'b0;
        @(negedge ck);
        checks++; if ({busy_a, done_a, pass_a, pi_a} !== 6'b0) begin failures++; $display("FAIL abort_run got=%b exp=000000", {busy_a, done_a, pass_a, pi_a}); end
        @(negedge ck);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_stay got=%b exp=0", busy_a); end
        // START while busy is ignored
        sb_q.push_back('{sig: 16'h0000, pass: 1'b1});
        start_a = 1'b1;
        @(posedge ck); #1 start_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ck);
            start_a = 1'b0;
            if (!busy_a) break;
            busy_n++;
            if (busy_n == 2 || busy_n == 6) start_a = 1'b1;
        end
        checks++; if (busy_n != 9) begin failures++; $display("FAIL busy_restart got=%0d exp=9", busy_n); end
        e = sb_q.pop_front();
        checks++; if ({done_a, pass_a, sig_a} !== {1'b1, e.pass, e.sig}) begin
            failures++; $display("FAIL restart_result got=%b/%b/%h exp=1/%b/%h", done_a, pass_a, sig_a, e.pass, e.sig);
        end
        // RST mid-RUN
        @(negedge ck) start_a = 1'b1;
        @(posedge ck); #1 start_a = 1'b0;
        repeat (5) @(negedge ck);
        rst = 1'b1;
        @(posedge ck); #1 rst = 1'b0;
        @(negedge ck);
        checks++; if ({busy_a, done_a, pass_a, pi_a, sig_a} !== 22'h0) begin
            failures++; $display("FAIL rst_midrun got=%h exp=0", {busy_a, done_a, pass_a, pi_a, sig_a});
        end
    endtask

    task automatic test_full_run(input bit fault, output logic [15:0] sig_out);
        logic [15:0] m  = 16'hACE1;
        logic [15:0] mm = 16'h0000;
        int          pi_bad = 0;
        exp_t        e;
        @(negedge ck) core_clr = 1'b1;
        @(posedge ck); #1 core_clr = 1'b0;
        @(negedge ck) start_e = 1'b1;
        @(posedge ck); #1 start_e = 1'b0;
        repeat (4) @(negedge ck);
        for (int r = 0; r < 1024; r++) begin
            @(negedge ck);
            if (pi_e !== m_pi(m)) pi_bad++;
            fault_mask = (fault && r == 100) ? 6'h08 : 6'h00;
            mm = m_misr(mm, core_st ^ fault_mask);
            m  = m_lfsr(m);
        end
        sb_q.push_back('{sig: mm, pass: (mm == 16'h0000)});
        @(negedge ck);
        fault_mask = 6'h00;
        checks++; if ({busy_e, done_e} !== 2'b10) begin failures++; $display("FAIL full_cmp f=%0d got=%b exp=10", fault, {busy_e, done_e}); end
        @(negedge ck);
        checks++; if (pi_bad != 0) begin failures++; $display("FAIL full_pi f=%0d bad_cycles=%0d exp=0", fault, pi_bad); end
        e = sb_q.pop_front();
        checks++; if ({done_e, pass_e, sig_e} !== {1'b1, e.pass, e.sig}) begin
            failures++; $display("FAIL full_result f=%0d got=%b/%b/%h exp=1/%b/%h", fault, done_e, pass_e, sig_e, e.pass, e.sig);
        end
        sig_out = sig_e;
    endtask

    initial begin
        logic [15:0] s_clean, s_fault;
        test_reset();
        test_timing();
        test_misr();
        test_seed_zero();
        test_abort();
        test_full_run(1'b0, s_clean);
        test_full_run(1'b1, s_fault);
        checks++;
        if (s_fault === s_clean) begin failures++; $display("FAIL fault_detect got=%h exp!=%h", s_fault, s_clean); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
